// File: rtl/traffic_pkg.sv
// Shared phase encoding, default phase durations and a small helper
// for the traffic controller.
package traffic_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_GREEN  = 2'd0;
  localparam phase_t PH_YELLOW = 2'd1;
  localparam phase_t PH_ALLRED = 2'd2;
  localparam phase_t PH_WALK   = 2'd3;

  localparam int DEF_GREEN_CYC  = 8;
  localparam int DEF_YELLOW_CYC = 2;
  localparam int DEF_ALLRED_CYC = 1;
  localparam int DEF_WALK_CYC   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_argmax.sv
// Combinational argmax over packed per-road counts; ties resolve to the
// lowest road index.
module traffic_argmax #(
  parameter int N_ROADS = 4,
  parameter int CNT_W   = 16
) (
  input  logic [N_ROADS*CNT_W-1:0]   traffic,
  output logic [$clog2(N_ROADS)-1:0] idx
);

  localparam int ROAD_W = $clog2(N_ROADS);

  logic [CNT_W-1:0] best;

  // Linear scan; strict greater-than keeps the earliest of equal counts.
  always_comb begin
    idx  = '0;
    best = traffic[0 +: CNT_W];
    for (int i = 1; i < N_ROADS; i++) begin
      if (traffic[i*CNT_W +: CNT_W] > best) begin
        best = traffic[i*CNT_W +: CNT_W];
        idx  = ROAD_W'(i);
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-road traffic light controller: round-robin GREEN/YELLOW/ALLRED cycle
// with emergency preemption toward the busiest road.
// Optional pedestrian WALK phase enabled by macro TRAFFIC_CTRL_N_PED_EN.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_ROADS    = 4,
  parameter int CNT_W      = 16,
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC
`ifdef TRAFFIC_CTRL_N_PED_EN
  ,
  parameter int WALK_CYC   = DEF_WALK_CYC
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       emerg,
  input  logic [N_ROADS*CNT_W-1:0]   traffic,
  output logic [N_ROADS-1:0]         red,
  output logic [N_ROADS-1:0]         green,
  output logic [N_ROADS-1:0]         yellow,
  output logic [$clog2(N_ROADS)-1:0] active_road,
  output logic [1:0]                 phase,
  output logic [CNT_W-1:0]           out
`ifdef TRAFFIC_CTRL_N_PED_EN
  ,
  input  logic                       ped_req,
  output logic                       walk
`endif
);

  localparam int ROAD_W = $clog2(N_ROADS);
`ifdef TRAFFIC_CTRL_N_PED_EN
  localparam int WALK_D = WALK_CYC;
`else
  localparam int WALK_D = 1;
`endif
  localparam int MAX_CYC = max2(max2(GREEN_CYC, YELLOW_CYC), max2(ALLRED_CYC, WALK_D));
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] G_LD = TMR_W'(GREEN_CYC - 1);
  localparam logic [TMR_W-1:0] Y_LD = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] A_LD = TMR_W'(ALLRED_CYC - 1);
`ifdef TRAFFIC_CTRL_N_PED_EN
  localparam logic [TMR_W-1:0] W_LD = TMR_W'(WALK_D - 1);
`endif

  phase_t            ph;
  logic [ROAD_W-1:0] road;
  logic [ROAD_W-1:0] amax;
  logic [ROAD_W-1:0] nxt_road;
  logic [TMR_W-1:0]  tmr;
`ifdef TRAFFIC_CTRL_N_PED_EN
  logic              ped_pend;
`endif

  traffic_argmax #(
    .N_ROADS (N_ROADS),
    .CNT_W   (CNT_W)
  ) u_argmax (
    .traffic (traffic),
    .idx     (amax)
  );

  // Road to serve after the all-red gap: busiest under emergency, else next in turn.
  always_comb begin
    if (emerg)
      nxt_road = amax;
    else if (road == ROAD_W'(N_ROADS - 1))
      nxt_road = '0;
    else
      nxt_road = road + 1'b1;
  end

  // Phase sequencer with per-phase down-counter; a phase ends when tmr reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph   <= PH_GREEN;
      road <= '0;
      tmr  <= G_LD;
`ifdef TRAFFIC_CTRL_N_PED_EN
      ped_pend <= 1'b0;
`endif
    end else begin
`ifdef TRAFFIC_CTRL_N_PED_EN
      if (ped_req) ped_pend <= 1'b1;
`endif
      case (ph)
        PH_GREEN: begin
          if (emerg && amax != road) begin
            ph  <= PH_YELLOW;
            tmr <= Y_LD;
          end else if (emerg) begin
            tmr <= G_LD;
          end else if (tmr == '0) begin
            ph  <= PH_YELLOW;
            tmr <= Y_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PH_YELLOW: begin
          if (tmr == '0) begin
            ph  <= PH_ALLRED;
            tmr <= A_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PH_ALLRED: begin
          if (tmr == '0) begin
`ifdef TRAFFIC_CTRL_N_PED_EN
            if (ped_pend && !emerg) begin
              ph       <= PH_WALK;
              tmr      <= W_LD;
              ped_pend <= 1'b0;
            end else begin
              ph   <= PH_GREEN;
              road <= nxt_road;
              tmr  <= G_LD;
            end
`else
            ph   <= PH_GREEN;
            road <= nxt_road;
            tmr  <= G_LD;
`endif
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
`ifdef TRAFFIC_CTRL_N_PED_EN
        PH_WALK: begin
          if (tmr == '0) begin
            ph   <= PH_GREEN;
            road <= nxt_road;
            tmr  <= G_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
`endif
        default: begin
          ph   <= PH_GREEN;
          road <= '0;
          tmr  <= G_LD;
        end
      endcase
    end
  end

  // Lamp decode: one lamp per road, only the active road ever leaves red.
  always_comb begin
    red    = '1;
    green  = '0;
    yellow = '0;
    if (ph == PH_GREEN) begin
      green[road] = 1'b1;
      red[road]   = 1'b0;
    end else if (ph == PH_YELLOW) begin
      yellow[road] = 1'b1;
      red[road]    = 1'b0;
    end
  end

  assign active_road = road;
  assign phase       = ph;
  assign out         = traffic[int'(road)*CNT_W +: CNT_W];
`ifdef TRAFFIC_CTRL_N_PED_EN
  assign walk        = (ph == PH_WALK);
`endif

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n (N_ROADS=4, 8/2/1 timing).
// Cycle k is the state sampled just before the k-th rising edge after
// reset release; expected states are queued per scenario and popped as
// the run reaches each cycle.
module tb_traffic_ctrl_n;

  localparam int N  = 4;
  localparam int CW = 16;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    int         road;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            emerg = 1'b0;
  logic [N*CW-1:0] traffic = '0;
  logic [N-1:0]    red, green, yellow;
  logic [1:0]      active_road;
  logic [1:0]      phase;
  logic [CW-1:0]   out;
`ifdef TRAFFIC_CTRL_N_PED_EN
  logic            ped_req = 1'b0;
  logic            walk;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  int    cur_cyc = 0;
  string scn = "";
  exp_t  exp_q[$];

  traffic_ctrl_n #(.N_ROADS(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .emerg       (emerg),
    .traffic     (traffic),
    .red         (red),
    .green       (green),
    .yellow      (yellow),
    .active_road (active_road),
    .phase       (phase),
    .out         (out)
`ifdef TRAFFIC_CTRL_N_PED_EN
    ,
    .ped_req     (ped_req),
    .walk        (walk)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s cyc=%0d got=%0h exp=%0h", scn, tag, cur_cyc, got, exp);
    end
  endtask

  task automatic set_traffic(input int t0, input int t1, input int t2, input int t3);
    traffic = {CW'(t3), CW'(t2), CW'(t1), CW'(t0)};
  endtask

  task automatic push_span(input int from, input int to, input logic [1:0] ph, input int road);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc = c; e.ph = ph; e.road = road;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_state(input logic [1:0] ph, input int road, input logic walk_exp);
    logic [N-1:0] g, y, r;
    logic [CW-1:0] tv;
    g = (ph == 2'd0) ? N'(1 << road) : '0;
    y = (ph == 2'd1) ? N'(1 << road) : '0;
    r = ~(g | y);
    tv = traffic[road*CW +: CW];
    chk("phase", 32'(phase), 32'(ph));
    chk("road", 32'(active_road), 32'(road));
    chk("green", 32'(green), 32'(g));
    chk("yellow", 32'(yellow), 32'(y));
    chk("red", 32'(red), 32'(r));
    chk("out", 32'(out), 32'(tv));
`ifdef TRAFFIC_CTRL_N_PED_EN
    chk("walk", 32'(walk), 32'(walk_exp));
`else
    if (walk_exp) chk("walk_absent", 32'(phase), 32'd3);
`endif
  endtask

  // Assert reset at a falling edge, check the reset state, release at the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    emerg = 1'b0;
`ifdef TRAFFIC_CTRL_N_PED_EN
    ped_req = 1'b0;
`endif
    #1;
    cur_cyc = -1;
    check_state(2'd0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive per-cycle inputs, pop every expectation due this cycle.
  task automatic run_scn(input int ncyc, input int e_lo, input int e_hi, input int ped_cyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      cur_cyc = k;
      emerg = (k >= e_lo && k <= e_hi);
`ifdef TRAFFIC_CTRL_N_PED_EN
      ped_req = (k == ped_cyc);
`else
      if (ped_cyc < -1) emerg = 1'b0;
`endif
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == k) begin
        e = exp_q.pop_front();
        check_state(e.ph, e.road, e.ph == 2'd3);
      end
    end
    emerg = 1'b0;
`ifdef TRAFFIC_CTRL_N_PED_EN
    ped_req = 1'b0;
`endif
    if (exp_q.size() != 0) begin
      chk("unconsumed", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=hang exp=finish", cur_cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: free run round robin, back to road0 at cycle 44.
    scn = "s1";
    set_traffic(3, 7, 11, 13);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push_span(11*r,     11*r + 7, 2'd0, r);
      push_span(11*r + 8, 11*r + 9, 2'd1, r);
      push_span(11*r + 10, 11*r + 10, 2'd2, r);
    end
    push_span(44, 45, 2'd0, 0);
    run_scn(46, -1, -2, -1);

    // Scenario 2: preemption toward busiest road1.
    scn = "s2";
    set_traffic(10, 50, 20, 30);
    do_reset();
    push_span(0, 3, 2'd0, 0);
    push_span(4, 5, 2'd1, 0);
    push_span(6, 6, 2'd2, 0);
    push_span(7, 12, 2'd0, 1);
    run_scn(13, 3, 1000, -1);

    // Scenario 3: emergency on the already-green busiest road holds green.
    scn = "s3";
    set_traffic(90, 5, 5, 5);
    do_reset();
    push_span(0, 28, 2'd0, 0);
    push_span(29, 30, 2'd1, 0);
    run_scn(31, 2, 20, -1);

    // Scenario 4: emergency only at ALLRED exit with a tie between roads 0 and 1.
    scn = "s4";
    set_traffic(40, 40, 10, 10);
    do_reset();
    push_span(0, 7, 2'd0, 0);
    push_span(8, 9, 2'd1, 0);
    push_span(10, 10, 2'd2, 0);
    push_span(11, 18, 2'd0, 0);
    run_scn(19, 10, 10, -1);

    // Scenario 5: asynchronous reset in the middle of road2 YELLOW.
    scn = "s5";
    set_traffic(1, 2, 3, 4);
    do_reset();
    push_span(22, 29, 2'd0, 2);
    push_span(30, 30, 2'd1, 2);
    run_scn(31, -1, -2, -1);
    @(posedge clk);
    #2;
    cur_cyc = 31;
    chk("pre_rst_phase", 32'(phase), 32'd1);
    rst = 1'b0;
    #1;
    check_state(2'd0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    push_span(0, 7, 2'd0, 0);
    push_span(8, 9, 2'd1, 0);
    run_scn(10, -1, -2, -1);

`ifdef TRAFFIC_CTRL_N_PED_EN
    // Scenario 6: pedestrian request inserts WALK after road0 ALLRED.
    scn = "s6";
    set_traffic(5, 6, 7, 8);
    do_reset();
    push_span(0, 7, 2'd0, 0);
    push_span(8, 9, 2'd1, 0);
    push_span(10, 10, 2'd2, 0);
    push_span(11, 14, 2'd3, 0);
    push_span(15, 17, 2'd0, 1);
    run_scn(18, -1, -2, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 SHALL provide parameter N_ROADS, default 4, number of roads (legal range 2..16).
REQ-002 SHALL provide parameter CNT_W, default 16, width of each per-road traffic count.
REQ-003 SHALL provide parameters GREEN_CYC, YELLOW_CYC and ALLRED_CYC, defaults 8, 2 and 1, giving phase durations in clocks (each at least 1).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL provide port emerg, input, 1 bit: emergency preemption request, level-sensitive.
REQ-007 SHALL provide port traffic, input, N_ROADS*CNT_W bits: packed counts, road i at bits [i*CNT_W +: CNT_W], unsigned.
REQ-008 SHALL provide ports red, green and yellow, outputs, N_ROADS bits each: per-road lamps, bit i = road i.
REQ-009 SHALL provide port active_road, output, clog2(N_ROADS) bits: index of the road currently served.
REQ-010 SHALL provide port phase, output, 2 bits: current phase, GREEN=0, YELLOW=1, ALLRED=2, WALK=3.
REQ-011 SHALL provide port out, output, CNT_W bits: the traffic count of active_road.

Function
REQ-012 Lamps: SHALL drive the active road green in GREEN and yellow in YELLOW; all other roads red; every road red in ALLRED and WALK; exactly one lamp per road is asserted in every cycle.
REQ-013 Phase timing: a down-counter SHALL be loaded with the phase duration minus 1 on phase entry; the phase SHALL end on the cycle the counter reads 0.
REQ-014 Phase order: GREEN SHALL be followed by YELLOW, YELLOW by ALLRED, and ALLRED by GREEN of the next road.
REQ-015 Next road on ALLRED exit: when emerg=0, SHALL be (active_road+1) mod N_ROADS, wrapping from N_ROADS-1 to 0; when emerg=1, SHALL be the argmax road.
REQ-016 Argmax SHALL be the road with the largest traffic count; on a tie, SHALL be the lowest index among the tied roads.
REQ-017 emerg=1 in GREEN with argmax different from active_road: SHALL enter YELLOW on the next clock, regardless of the remaining green time.
REQ-018 emerg=1 in GREEN with argmax equal to active_road: SHALL stay in GREEN and reload the counter to GREEN_CYC-1 every cycle emerg is held.
REQ-019 emerg SHALL NOT shorten YELLOW or ALLRED; the target road SHALL be chosen only at ALLRED exit.
REQ-020 out SHALL be combinational from traffic and active_road, with zero latency.

Reset
REQ-021 On rst=0, SHALL immediately (asynchronously) set active_road=0, phase=GREEN and counter=GREEN_CYC-1, and clear any pending pedestrian request.
REQ-022 During reset, SHALL drive green=1 on road 0 and red on all other roads; out SHALL equal traffic road 0.
REQ-023 Reset asserted mid-phase SHALL abandon that phase; after release, operation SHALL restart with a full GREEN_CYC green on road 0.

Configuration
REQ-024 Macro TRAFFIC_CTRL_N_PED_EN defined: SHALL add input ped_req (1 bit), output walk (1 bit) and parameter WALK_CYC (default 4).
REQ-025 With the macro, a ped_req pulse SHALL set a sticky pending flag; at ALLRED exit with the flag set and emerg=0, SHALL enter WALK (all red, walk=1) for WALK_CYC cycles, clear the flag, then apply REQ-015.
REQ-026 With the macro, emerg=1 at ALLRED exit SHALL skip WALK and keep the flag pending.
REQ-027 Without the macro, the ped_req and walk ports and the WALK phase SHALL be absent; phase encoding 3 SHALL be unreachable.

Structure
REQ-028 Package traffic_pkg SHALL hold the phase encoding and the default durations.
REQ-029 Argmax SHALL live in combinational sub-module traffic_argmax, parameterised by N_ROADS and CNT_W.
REQ-030 The counter width SHALL be clog2 of the largest duration plus 1.

Verification (N_ROADS=4, GREEN/YELLOW/ALLRED = 8/2/1 clocks, cycle 0 = first edge after reset release)
REQ-031 Scenario 1, free run, emerg=0: road0 green cycles 0-7, yellow 8-9, allred 10; road1 green from 11; back to road0 green at cycle 44.
REQ-032 Scenario 2, traffic={10,50,20,30}, emerg high from cycle 3: yellow 4-5, allred 6, road1 green at 7, out=50.
REQ-033 Scenario 3, traffic={90,5,5,5}, emerg held cycles 2-20: road0 stays green; after release, exactly 8 more green cycles.
REQ-034 Scenario 4, traffic={40,40,10,10}, emerg=1 at ALLRED exit: road0 is selected (tie goes to the lower index).
REQ-035 Scenario 5, rst pulled low mid-YELLOW of road2: green[0]=1 in the same cycle without waiting for a clock edge; road0 gets a full 8-cycle green after release.
REQ-036 Scenario 6, TRAFFIC_CTRL_N_PED_EN defined, WALK_CYC=4: ped_req pulse at cycle 2 gives walk=1 at cycles 11-14 with all red, then road1 green at 15.
